ex_result_stage: RTL
====================

Name: ex_result_stage

Overview:
- Execute-to-memory pipeline stage that sits directly downstream of the ALU in the example RISC-V core.
- Captures the ALU outputs Q, MUL_OUT and CMP together with instruction sideband.
- Selects the writeback value, resolves branches and jumps into a one-cycle PC redirect, and flags misaligned targets.
- Presents a registered result to the memory stage over a valid/ready handshake and drives the forwarding path.

Parameters:
- XLEN, 32, datapath width; must match the ALU operand width.
- RA_W, 5, destination register address width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RES_n  input  1  asynchronous active-low reset.
- IN_VALID  input  1  execute stage presents an instruction this cycle.
- IN_READY  output  1  stage accepts the presented instruction this cycle.
- ALU_Q  input  XLEN  ALU Q output (arithmetic/logic result, or rs1+imm for JALR).
- ALU_MUL  input  XLEN  ALU MUL_OUT output.
- ALU_CMP  input  1  ALU CMP output.
- SEL_MUL  input  1  result comes from ALU_MUL instead of ALU_Q.
- IS_BRANCH  input  1  conditional branch; taken when ALU_CMP=1.
- IS_JUMP  input  1  JAL or JALR; always taken.
- IS_JALR  input  1  jump target is ALU_Q with bit 0 cleared (valid only with IS_JUMP).
- PC  input  XLEN  PC of the instruction.
- IMM  input  XLEN  sign-extended branch/JAL offset.
- RD  input  RA_W  destination register.
- RD_WE  input  1  instruction writes RD.
- FLUSH  input  1  discard the held entry and any entry accepted this cycle.
- OUT_VALID  output  1  registered entry valid toward the memory stage.
- OUT_READY  input  1  memory stage consumes the entry.
- OUT_RESULT  output  XLEN  registered writeback value.
- OUT_RD  output  RA_W  registered destination register.
- OUT_RD_WE  output  1  registered write enable; forced 0 when RD=0 or the entry is misaligned.
- REDIRECT  output  1  one-cycle pulse: fetch must load REDIRECT_PC.
- REDIRECT_PC  output  XLEN  branch or jump target, valid while REDIRECT=1.
- MISALIGNED  output  1  registered flag: taken target has bits [1:0] != 0.

Behaviour:
- Reset (asynchronous, RES_n=0): OUT_VALID=0, OUT_RESULT=0, OUT_RD=0, OUT_RD_WE=0, REDIRECT=0, REDIRECT_PC=0, MISALIGNED=0. Deassertion is sampled on the clock; the first accept is possible on the first edge after release.
- Reset in the middle of a stall drops the held entry and any pending redirect.
- IN_READY = !OUT_VALID | OUT_READY (combinational; a full stage passes straight through when the memory stage drains).
- Accept happens when IN_VALID & IN_READY & !FLUSH. Latency is 1: the accepted instruction appears on OUT_* on the next edge.
- Result select, in priority order: IS_JUMP gives PC+4 (wraps mod 2^XLEN); else SEL_MUL gives ALU_MUL; else ALU_Q. Branches carry RD_WE=0 from decode; the stage passes it through.
- taken = IS_JUMP | (IS_BRANCH & ALU_CMP).
- Target = IS_JALR ? {ALU_Q[XLEN-1:1],1'b0} : PC+IMM. PC+IMM is computed modulo 2^XLEN and wraps silently.
- A taken accept with target[1:0]==0: REDIRECT=1 for exactly one cycle after the accept edge, REDIRECT_PC=target, MISALIGNED=0.
- A taken accept with target[1:0]!=0: REDIRECT=0, MISALIGNED=1 with the entry, OUT_RD_WE=0.
- A not-taken accept, or a cycle with no accept: REDIRECT=0 on the next edge.
- Hold: when OUT_VALID=1 & OUT_READY=0, all OUT_* and MISALIGNED are stable and IN_READY=0.
- Drain with no new accept: OUT_VALID goes to 0 on the edge; OUT_RESULT, OUT_RD and MISALIGNED keep their values (don't-care), and OUT_RD_WE goes to 0.
- FLUSH=1 has priority over accept and hold. On the edge: OUT_VALID=0, OUT_RD_WE=0, MISALIGNED=0, REDIRECT=0.
- A REDIRECT pulse already high while FLUSH is asserted is still consumed by fetch; only a new pulse is suppressed.
- Simultaneous drain and accept (OUT_VALID=1, OUT_READY=1, IN_VALID=1): the new entry replaces the old one on the edge with no bubble.

Test Plan:
- ADD: IN_VALID, ALU_Q=0x0000_0005, SEL_MUL=0, RD=3, RD_WE=1, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_RESULT=5, OUT_RD=3, OUT_RD_WE=1, REDIRECT=0.
- BEQ taken: PC=0x100, IMM=0xFFFF_FFF0, ALU_CMP=1 -> REDIRECT=1 for one cycle, REDIRECT_PC=0xF0. Same case with ALU_CMP=0 -> REDIRECT stays 0.
- JALR: ALU_Q=0x0000_2003, PC=0x40, RD=1 -> OUT_RESULT=0x44, REDIRECT_PC=0x2002, MISALIGNED=1, REDIRECT=0, OUT_RD_WE=0. With ALU_Q=0x2001 -> REDIRECT_PC=0x2000, REDIRECT=1, OUT_RD_WE=1.
- Back-pressure: OUT_READY=0 for 3 cycles while IN_VALID=1 with a MUL (ALU_MUL=0x0000_0030) -> IN_READY=0 and OUT_RESULT=0x30 held for all 3 cycles. When OUT_READY=1, the next instruction is accepted in the same cycle with no bubble.
- FLUSH: FLUSH=1 in the same cycle as a taken JAL accept -> OUT_VALID=0 and REDIRECT=0 next cycle.
- Reset: RES_n low mid-stall -> all outputs 0 immediately (asynchronously). RD=0 with RD_WE=1 -> OUT_RD_WE=0.

Source files
------------

// File: rtl/ex_result_stage_if.sv
// Handshake bundles around the execute result stage.
// ex_in_if carries one instruction from the execute stage (ALU outputs plus
// decode sideband). ex_out_if carries the registered entry to the memory stage.

interface ex_in_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [XLEN-1:0] ALU_Q;
    logic [XLEN-1:0] ALU_MUL;
    logic            ALU_CMP;
    logic            SEL_MUL;
    logic            IS_BRANCH;
    logic            IS_JUMP;
    logic            IS_JALR;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] IMM;
    logic [RA_W-1:0] RD;
    logic            RD_WE;

    // Execute stage side: presents the instruction, observes ready.
    modport master (
        output IN_VALID, ALU_Q, ALU_MUL, ALU_CMP, SEL_MUL,
               IS_BRANCH, IS_JUMP, IS_JALR, PC, IMM, RD, RD_WE,
        input  IN_READY
    );

    // Result stage side: consumes the instruction, drives ready.
    modport slave (
        input  IN_VALID, ALU_Q, ALU_MUL, ALU_CMP, SEL_MUL,
               IS_BRANCH, IS_JUMP, IS_JALR, PC, IMM, RD, RD_WE,
        output IN_READY
    );
endinterface

interface ex_out_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] OUT_RESULT;
    logic [RA_W-1:0] OUT_RD;
    logic            OUT_RD_WE;
    logic            MISALIGNED;

    // Result stage side: presents the registered entry.
    modport master (
        output OUT_VALID, OUT_RESULT, OUT_RD, OUT_RD_WE, MISALIGNED,
        input  OUT_READY
    );

    // Memory stage side: consumes the entry.
    modport slave (
        input  OUT_VALID, OUT_RESULT, OUT_RD, OUT_RD_WE, MISALIGNED,
        output OUT_READY
    );
endinterface

// File: rtl/ex_result_stage.sv
// Execute-to-memory pipeline register for the example RISC-V core.
// Captures the ALU result with its sideband, picks the writeback value,
// resolves branches/jumps into a one-cycle fetch redirect and flags
// misaligned control-flow targets. One-entry skid-free stage: a full stage
// accepts a new instruction in the same cycle the memory stage drains it.

module ex_result_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            CLK,
    input  logic            RES_n,
    input  logic            FLUSH,
    ex_in_if.slave          in_bus,
    ex_out_if.master        out_bus,
    output logic            REDIRECT,
    output logic [XLEN-1:0] REDIRECT_PC
);

    logic            in_ready;
    logic            accept;
    logic            taken;
    logic            target_misaligned;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result_sel;

    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic [RA_W-1:0] out_rd_q;
    logic            out_rd_we_q;
    logic            misaligned_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;

    // Room for a new entry when empty or when the held entry drains this cycle.
    assign in_ready = !out_valid_q || out_bus.OUT_READY;
    assign accept   = in_bus.IN_VALID && in_ready && !FLUSH;

    // Writeback select, branch resolution and target alignment check.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        pc_plus4    = in_bus.PC + XLEN'(4);
        pc_plus_imm = in_bus.PC + in_bus.IMM;
        result_sel  = in_bus.ALU_Q;
        target      = pc_plus_imm;

        if (in_bus.IS_JUMP) begin
            result_sel = pc_plus4;
        end else if (in_bus.SEL_MUL) begin
            result_sel = in_bus.ALU_MUL;
        end

        if (in_bus.IS_JALR) begin
            target = {in_bus.ALU_Q[XLEN-1:1], 1'b0};
        end

        taken             = in_bus.IS_JUMP || (in_bus.IS_BRANCH && in_bus.ALU_CMP);
        target_misaligned = taken && (target[1:0] != 2'b00);
    end

    // Stage register: flush beats accept beats drain beats hold.
    always_ff @(posedge CLK or negedge RES_n) begin
        if (!RES_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            misaligned_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (FLUSH) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            out_valid_q  <= 1'b0;
            out_rd_we_q  <= 1'b0;
            misaligned_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_result_q <= result_sel;
            out_rd_q     <= in_bus.RD;
            // x0 is never written, and a faulting jump must not write its link register.
            out_rd_we_q  <= in_bus.RD_WE && (in_bus.RD != '0) && !target_misaligned;
            misaligned_q <= target_misaligned;
            redirect_q   <= taken && !target_misaligned;
            if (taken) begin
                redirect_pc_q <= target;
            end
        end else begin
            // Redirect is a single-cycle pulse regardless of back-pressure.
            redirect_q <= 1'b0;
            if (out_bus.OUT_READY) begin
                out_valid_q <= 1'b0;
                out_rd_we_q <= 1'b0;
            end
        end
    end

    assign in_bus.IN_READY    = in_ready;
    assign out_bus.OUT_VALID  = out_valid_q;
    assign out_bus.OUT_RESULT = out_result_q;
    assign out_bus.OUT_RD     = out_rd_q;
    assign out_bus.OUT_RD_WE  = out_rd_we_q;
    assign out_bus.MISALIGNED = misaligned_q;
    assign REDIRECT           = redirect_q;
    assign REDIRECT_PC        = redirect_pc_q;

endmodule
